// File: rtl/hs_bridge_pkg.sv
// hs_bridge_pkg: shared types for the hiscore RAM bridge.
// State encoding and the out-of-window read value.
package hs_bridge_pkg;

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DRAIN,
    ST_HS,
    ST_REL
  } state_t;

  localparam logic [7:0] OOR_RDATA = 8'hFF;

endpackage

// File: rtl/hs_ram_bridge.sv
// hs_ram_bridge: work-RAM arbiter between the Z80 and the hiscore engine.
// Windowed, fixed-latency hiscore access with a one-entry early-write buffer.
module hs_ram_bridge
  import hs_bridge_pkg::*;
#(
  parameter int          AW   = 11,
  parameter logic [15:0] BASE = 16'hE000,
  parameter int          GAP  = 2
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          hs_access,
  input  logic [15:0]   hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  output logic [7:0]    hs_data_out,
  output logic          hs_owned,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          viol
);

  localparam logic [3:0] GAP_W = 4'(GAP);

  state_t r_state;
  state_t w_next;

  logic [2:0]  r_idle;
  logic [3:0]  w_idle_nx;
  logic        r_pend_v;
  logic [15:0] r_pend_addr;
  logic [7:0]  r_pend_data;
  logic        r_inr_d;
  logic [7:0]  r_hs_dout;
  logic        r_viol;

  logic        w_in_hs;
  logic        w_in_drain;
  logic        w_issue;
  logic [15:0] w_hs_a;
  logic [7:0]  w_hs_d;
  logic        w_hs_we;
  logic [16:0] w_hs_diff;
  logic        w_hs_inr;
  logic        w_pend_ld;

  assign w_in_hs    = (r_state == ST_HS);
  assign w_in_drain = (r_state == ST_DRAIN);
  assign w_idle_nx  = {1'b0, r_idle} + 4'd1;

  // a buffered early write takes the port on the first owned cycle
  assign w_issue = w_in_hs && r_pend_v;
  assign w_hs_a  = w_issue ? r_pend_addr : hs_address;
  assign w_hs_d  = w_issue ? r_pend_data : hs_data_in;
  assign w_hs_we = w_issue | hs_write;

  // window check in 17 bits so addresses below BASE wrap negative
  assign w_hs_diff = {1'b0, w_hs_a} - {1'b0, BASE};
  assign w_hs_inr  = (w_hs_diff[16:AW] == '0);

  // a live write colliding with the buffered one is pushed into the buffer
  assign w_pend_ld = hs_write &&
    (((r_state == ST_CPU) && hs_access) ||
     (w_in_drain && hs_access) ||
     w_issue);

  assign hs_data_out = r_hs_dout;
  assign viol        = r_viol;
  assign cpu_dout    = ram_rdata;

  // state register
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) r_state <= ST_CPU;
    else       r_state <= w_next;
  end

  // next-state: handover only after GAP consecutive idle CPU cycles
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_CPU: begin
        if (hs_access) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!hs_access)
          w_next = ST_CPU;
        else if (!cpu_req && (w_idle_nx >= GAP_W))
          w_next = ST_HS;
      end
      ST_HS: begin
        if (!hs_access) w_next = ST_REL;
      end
      ST_REL: w_next = ST_CPU;
      default: w_next = ST_CPU;
    endcase
  end

  // RAM port mux and ownership flag
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_din;
    ram_we    = cpu_req & cpu_we;
    hs_owned  = 1'b0;
    unique case (r_state)
      ST_HS: begin
        ram_addr  = w_hs_diff[AW-1:0];
        ram_wdata = w_hs_d;
        ram_we    = w_hs_we & w_hs_inr;
        hs_owned  = 1'b1;
      end
      ST_REL: ram_we = 1'b0;
      default: ;
    endcase
  end

  // idle counter: consecutive cpu_req=0 cycles while draining
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)
      r_idle <= 3'd0;
    else if (!w_in_drain || cpu_req)
      r_idle <= 3'd0;
    else if (r_idle != 3'd7)
      r_idle <= r_idle + 3'd1;
  end

  // one-entry pending write; dropped on abort or once issued
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= 16'h0000;
      r_pend_data <= 8'h00;
    end else if (w_pend_ld) begin
      r_pend_v    <= 1'b1;
      r_pend_addr <= hs_address;
      r_pend_data <= hs_data_in;
    end else if (!(w_in_drain && hs_access)) begin
      r_pend_v    <= 1'b0;
    end
  end

  // read path: window flag follows the RAM's one-cycle latency
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_inr_d   <= 1'b0;
      r_hs_dout <= 8'h00;
    end else begin
      r_inr_d <= w_hs_inr;
      if (w_in_hs)
        r_hs_dout <= r_inr_d ? ram_rdata : OOR_RDATA;
    end
  end

  // sticky flag for CPU accesses lost while hiscore owns the RAM
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)
      r_viol <= 1'b0;
    else if (cpu_req && (w_in_hs || (r_state == ST_REL)))
      r_viol <= 1'b1;
  end

endmodule

// File: tb/tb_hs_ram_bridge.sv
// tb_hs_ram_bridge: self-checking bench for hs_ram_bridge.
// Synchronous RAM model plus a read scoreboard.
module tb_hs_ram_bridge;

  localparam int AW = 11;

  logic          MCLK = 1'b0;
  logic          RESET;
  logic          hs_access;
  logic [15:0]   hs_address;
  logic [7:0]    hs_data_in;
  logic          hs_write;
  logic [7:0]    hs_data_out;
  logic          hs_owned;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_we;
  logic [7:0]    cpu_dout;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          viol;

  hs_ram_bridge #(
    .AW(AW),
    .BASE(16'hE000),
    .GAP(2)
  ) dut (
    .MCLK(MCLK),
    .RESET(RESET),
    .hs_access(hs_access),
    .hs_address(hs_address),
    .hs_data_in(hs_data_in),
    .hs_write(hs_write),
    .hs_data_out(hs_data_out),
    .hs_owned(hs_owned),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_we(cpu_we),
    .cpu_dout(cpu_dout),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .viol(viol)
  );

  always #5 MCLK = ~MCLK;

  logic [7:0] mem [0:(1<<AW)-1];

  always @(posedge MCLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [7:0] sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge MCLK);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    logic [7:0] x;
    hs_address = a;
    hs_write   = 1'b0;
    sb_q.push_back(e);
    cyc;
    cyc;
    x = sb_q.pop_front();
    chk("rd", hs_data_out, x);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    hs_address = a;
    hs_data_in = d;
    hs_write   = 1'b1;
    #1;
    chk("wr_we", ram_we, 1'b1);
    cyc;
    hs_write = 1'b0;
  endtask

  task automatic wait_own(input string tag, input int exp_k);
    int k;
    k = 0;
    while (!hs_owned && k < 10) begin
      cyc;
      k++;
    end
    chk(tag, k, exp_k);
  endtask

  task automatic rel;
    hs_access = 1'b0;
    hs_write  = 1'b0;
    cyc;
    chk("rel_owned", hs_owned, 1'b0);
    cyc;
  endtask

  logic [7:0] d0;
  logic [7:0] d1;

  initial begin
    RESET      = 1'b1;
    hs_access  = 1'b0;
    hs_address = 16'h0000;
    hs_data_in = 8'h00;
    hs_write   = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_din    = 8'h00;
    cpu_we     = 1'b0;
    repeat (2) @(posedge MCLK);
    #1;
    chk("rst_dout", hs_data_out, 8'h00);
    chk("rst_owned", hs_owned, 1'b0);
    chk("rst_viol", viol, 1'b0);
    RESET = 1'b0;
    cyc;

    // handover with idle CPU
    hs_access = 1'b1;
    wait_own("handover_lat", 3);

    // basic write then readback
    hs_address = 16'hE010;
    hs_data_in = 8'h5A;
    hs_write   = 1'b1;
    #1;
    chk("wr5a_we", ram_we, 1'b1);
    chk("wr5a_addr", ram_addr, 11'h010);
    chk("wr5a_data", ram_wdata, 8'h5A);
    cyc;
    hs_write = 1'b0;
    chk("mem_010", mem[11'h010], 8'h5A);
    rd(16'hE010, 8'h5A);

    // window edges
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    wr(16'hE000, d0);
    rd(16'hE000, d0);
    wr(16'hE7FF, d1);
    rd(16'hE7FF, d1);

    // out of window
    rd(16'hD000, 8'hFF);
    rd(16'hE800, 8'hFF);
    hs_address = 16'hE800;
    hs_data_in = 8'hC3;
    hs_write   = 1'b1;
    #1;
    chk("oor_we", ram_we, 1'b0);
    cyc;
    hs_write = 1'b0;
    rd(16'hE000, d0);
    rel;

    // CPU path after release
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 11'h123;
    cpu_din  = 8'h77;
    #1;
    chk("cpu_we", ram_we, 1'b1);
    chk("cpu_addr", ram_addr, 11'h123);
    cyc;
    cpu_we = 1'b0;
    cyc;
    chk("cpu_dout", cpu_dout, 8'h77);
    cpu_req = 1'b0;
    cyc;

    // handover blocked by a busy CPU
    hs_access = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cpu_req = (i % 2 == 1);
      #1;
      chk("blocked", hs_owned, 1'b0);
      cyc;
    end
    cpu_req = 1'b0;
    wait_own("blocked_lat", 2);
    rel;

    // early write buffered in DRAIN, collision deferred
    hs_access = 1'b1;
    cyc;
    hs_address = 16'hE001;
    hs_data_in = 8'h33;
    hs_write   = 1'b1;
    #1;
    chk("drain_we", ram_we, 1'b0);
    cyc;
    hs_write = 1'b0;
    cyc;
    chk("pend_owned", hs_owned, 1'b1);
    hs_address = 16'hE002;
    hs_data_in = 8'h44;
    hs_write   = 1'b1;
    #1;
    chk("pend_we", ram_we, 1'b1);
    chk("pend_addr", ram_addr, 11'h001);
    chk("pend_data", ram_wdata, 8'h33);
    cyc;
    hs_address = 16'hE005;
    hs_data_in = 8'h00;
    hs_write   = 1'b0;
    #1;
    chk("defer_we", ram_we, 1'b1);
    chk("defer_addr", ram_addr, 11'h002);
    chk("defer_data", ram_wdata, 8'h44);
    cyc;
    rd(16'hE001, 8'h33);
    rd(16'hE002, 8'h44);
    rel;

    // aborted DRAIN discards the buffer
    hs_access  = 1'b1;
    hs_address = 16'hE003;
    hs_data_in = 8'h99;
    hs_write   = 1'b1;
    cyc;
    hs_access = 1'b0;
    hs_write  = 1'b0;
    cyc;
    hs_access = 1'b1;
    wait_own("abort_lat", 3);
    chk("abort_drop", ram_we, 1'b0);
    cyc;

    // CPU access during ownership
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 11'h005;
    cpu_din  = 8'hAA;
    #1;
    chk("viol_we", ram_we, 1'b0);
    cyc;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    chk("viol_set", viol, 1'b1);
    rel;
    repeat (3) cyc;
    chk("viol_sticky", viol, 1'b1);

    // async reset mid-ownership
    hs_access = 1'b1;
    wait_own("ho_again", 3);
    rd(16'hE010, 8'h5A);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_owned", hs_owned, 1'b0);
    chk("arst_dout", hs_data_out, 8'h00);
    chk("arst_viol", viol, 1'b0);
    hs_access = 1'b0;
    cyc;
    RESET = 1'b0;
    cyc;
    chk("post_owned", hs_owned, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_ram_bridge.md
# hs_ram_bridge

Responder side of the hiscore RAM-access interface, instantiated inside the game core. It arbitrates the work-RAM port between the Z80 and the hiscore engine. It services the engine's reads and writes with fixed latency, and performs address-window decode. It also flags any CPU access that arrives while the hiscore engine owns the RAM.

## Interface
Parameters:
- AW, 11: work-RAM address width.
- BASE, 16'hE000: hiscore address mapped to RAM word 0.
- GAP, 2: consecutive idle CPU cycles required before handover (1..7).

Ports:
- MCLK  in  1  core clock; all logic rising-edge.
- RESET  in  1  reset, asynchronous, active-high.
- hs_access  in  1  level; hiscore engine requests RAM ownership.
- hs_address  in  16  hiscore address.
- hs_data_in  in  8  write data from hiscore.
- hs_write  in  1  one-cycle write strobe.
- hs_data_out  out  8  registered read data to hiscore.
- hs_owned  out  1  bridge currently grants RAM to hiscore.
- cpu_req  in  1  CPU RAM access this cycle.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_dout  out  8  RAM read data to CPU (ram_rdata passthrough).
- ram_addr  out  AW  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data; synchronous RAM, 1-cycle latency.
- viol  out  1  sticky: CPU access dropped during hiscore ownership.

## Operation
- State machine: CPU → DRAIN → HS → REL → CPU.
- CPU state: RAM port driven from cpu_*. ram_we = cpu_req & cpu_we.
- CPU→DRAIN when hs_access=1.
- DRAIN state:
  - CPU keeps the port.
  - An idle counter (3 bits) counts consecutive cycles with cpu_req=0 and clears on cpu_req=1.
  - Counter reaching GAP → HS.
  - hs_access dropping → CPU, with no RAM effect.
- HS state:
  - ram_addr = (hs_address − BASE)[AW-1:0].
  - in_range = hs_address ≥ BASE and hs_address − BASE < 2^AW, computed in 17-bit arithmetic.
  - ram_we = hs_write & in_range. ram_wdata = hs_data_in.
  - Out-of-range writes are dropped.
- Read path: hs_data_out ← in_range_d ? ram_rdata : 8'hFF, loaded every cycle in HS. in_range_d is in_range delayed one cycle. Outside HS, hs_data_out holds.
- HS→REL when hs_access=0. REL drives ram_we=0 for one cycle, then → CPU.
- Pending write:
  - An hs_write pulse in DRAIN (or in CPU with hs_access=1) is latched into a one-entry buffer holding address and data.
  - The buffered write is issued on the first HS cycle. A live hs_write in that same cycle is deferred one cycle.
  - A second pulse before HS overwrites the buffer.
  - The buffer is discarded if DRAIN aborts.
- cpu_req=1 in HS or REL: the access is ignored (ram_we from the CPU is forced 0) and viol is set. viol clears only on RESET.
- hs_owned = 1 in HS only.

## Timing
- Reset values: state CPU, hs_data_out 8'h00, viol 0, hs_owned 0, pending buffer empty, idle counter 0. ram_* follow the CPU mux.
- Read latency: hs_address stable at cycle N (in HS) → hs_data_out valid after the edge ending cycle N+1, i.e. 2 cycles.
- Handover latency: hs_access rise at cycle N, CPU idle → hs_owned=1 at cycle N+1+GAP.
- Release: hs_access fall at N → REL at N+1 → CPU owns at N+2.
- RESET mid-HS: state returns to CPU immediately (asynchronously); the pending write is lost.
- ram_* outputs are combinational from state and inputs. All state is registered.

## Structure
- Package hs_bridge_pkg holds:
  - state enum {ST_CPU, ST_DRAIN, ST_HS, ST_REL};
  - the out-of-range read constant 8'hFF.
- No sub-module. The pending-write buffer is two registers plus a valid bit, kept inline.

## Test plan
- Reset, hs_access=1, cpu_req=0 throughout → hs_owned rises 3 cycles after hs_access (GAP=2). Write 8'h5A at 16'hE010 → RAM[0x010]=8'h5A. Read of 16'hE010 returns 8'h5A two cycles later.
- Out of range: read 16'hD000 → hs_data_out=8'hFF. Write 16'hE800 (AW=11) → ram_we stays 0.
- Handover blocked: cpu_req pulsing every 2nd cycle during DRAIN → no handover. Once cpu_req stops → hs_owned after GAP idle cycles.
- Pending write: hs_write of 8'h33 at 16'hE001 during DRAIN → issued on the first HS cycle. A simultaneous live write of 8'h44 at 16'hE002 lands the next cycle.
- Violation: cpu_req=1 in HS → no RAM write, viol=1. viol stays 1 after return to CPU, until RESET.
- Async RESET asserted mid-HS → state CPU and hs_owned=0 without a clock edge. hs_data_out=8'h00.
